// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetches INST_W-bit words from synchronous program memory into a small
// prefetch FIFO and presents them to the decoder with a valid/ready handshake.
// A redirect from the execute stage flushes the FIFO and restarts fetching
// from the new address.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   read request to program memory
//   imem_rdata           read data, valid one cycle after imem_req
//   instruction_valid    head word/address are valid
//   instruction_ready    decoder accepts the head word this cycle
//   instruction          head word
//   instruction_addr     address the head word was fetched from
//   redirect             flush and restart fetching at redirect_addr
//   redirect_addr        absolute restart address
//
// state | meaning
// BOOT  | single idle cycle after reset release, no requests
// RUN   | normal fetching; redirects are handled within this state
module instruction_fetch #(
    parameter int INST_W   = 16,
    parameter int I_ADDR_W = 12,
    parameter int DEPTH    = 2,
    parameter logic [I_ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [I_ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                instruction_valid,
    input  logic                instruction_ready,
    output logic [INST_W-1:0]   instruction,
    output logic [I_ADDR_W-1:0] instruction_addr,
    input  logic                redirect,
    input  logic [I_ADDR_W-1:0] redirect_addr
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t              state, state_next;
    logic [I_ADDR_W-1:0] fetch_pc;
    logic [I_ADDR_W-1:0] req_addr;
    logic [INST_W-1:0]   fifo_data [DEPTH];
    logic [I_ADDR_W-1:0] fifo_addr [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [CNT_W-1:0]    inflight;
    logic [INST_W-1:0]   last_inst;
    logic [I_ADDR_W-1:0] last_addr;
    logic                pop, push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop       = instruction_valid & instruction_ready;
    // A response arriving in a redirect cycle belongs to the old stream and
    // is dropped simply by not pushing it.
    assign push      = (inflight != '0) && !redirect;
    assign imem_addr = fetch_pc;

    // Head is read from storage, never bypassed from imem_rdata; when empty
    // the last presented word is held.
    assign instruction      = instruction_valid ? fifo_data[rd_ptr] : last_inst;
    assign instruction_addr = instruction_valid ? fifo_addr[rd_ptr] : last_addr;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                // Slots already claimed (stored + in flight) minus the one
                // leaving this cycle must leave room for one more word.
                imem_req = !redirect &&
                           ((int'(count) + int'(inflight) - int'(pop)) < DEPTH);
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= BOOT;
            fetch_pc          <= RESET_VECTOR;
            req_addr          <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            inflight          <= '0;
            instruction_valid <= 1'b0;
            last_inst         <= '0;
            last_addr         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            state             <= state_next;
            count             <= count_next;
            instruction_valid <= (count_next != '0);
            inflight          <= imem_req ? CNT_W'(1) : '0;

            if (instruction_valid) begin
                last_inst <= fifo_data[rd_ptr];
                last_addr <= fifo_addr[rd_ptr];
            end

            if (imem_req) begin
                req_addr <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end

            if (redirect) begin
                fetch_pc <= redirect_addr;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= imem_rdata;
                    fifo_addr[wr_ptr] <= req_addr;
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

endmodule
